// File: rtl/i2c_arb_pkg.sv
// Shared encodings for the I2C requester arbiter: FSM states, operation type and field widths.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 8;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first pending requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_valid && pending[j]) begin
        gnt_valid = 1'b1;
        gnt[j]    = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c_master_top command port among NUM_REQ requesters, one transaction at a time.
// Optional master-ack watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | sample pending requests, grant and latch fields
// S_ISSUE | fields latched, master request raised next cycle
// S_WAIT  | master request held until matching ack (or watchdog)
// S_RESP  | one-cycle req_ack to granted requester
import i2c_arb_pkg::*;

module i2c_req_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_read,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [8*NUM_REQ-1:0]    req_dev_addr,
  input  logic [8*NUM_REQ-1:0]    req_reg_addr,
  input  logic [8*NUM_REQ-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [I2C_DATA_W-1:0]   req_rdata,
  output logic                    req_error,
  output logic                    busy,
  output logic                    i2c_read_req,
  input  logic                    i2c_read_req_ack,
  output logic                    i2c_write_req,
  input  logic                    i2c_write_req_ack,
  output logic [I2C_ADDR_W-1:0]   i2c_slave_dev_addr,
  output logic [I2C_ADDR_W-1:0]   i2c_slave_reg_addr,
  output logic [I2C_DATA_W-1:0]   i2c_write_data,
  input  logic [I2C_DATA_W-1:0]   i2c_read_data,
  input  logic                    i2c_error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t              state_q, state_d;
  arb_op_t                 op_q;
  logic [IDX_W-1:0]        ptr_q, idx_q, gnt_idx;
  logic [NUM_REQ-1:0]      pending, gnt_oh;
  logic                    gnt_valid;
  logic [I2C_ADDR_W-1:0]   dev_q, reg_q;
  logic [I2C_DATA_W-1:0]   wdata_q, rdata_q;
  logic                    err_q;
  logic                    ack_match;
  logic                    timeout_hit;

  assign pending = req_read | req_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .pending   (pending),
    .ptr       (ptr_q),
    .gnt       (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Only the ack matching the issued operation completes the transaction.
  assign ack_match = (state_q == S_WAIT) &&
                     ((op_q == OP_WRITE) ? i2c_write_req_ack : i2c_read_req_ack);

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_WAIT && !ack_match) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && !ack_match &&
                       (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    req_ack       = '0;
    busy          = (state_q != S_IDLE);
    i2c_write_req = 1'b0;
    i2c_read_req  = 1'b0;
    case (state_q)
      S_IDLE:  if (gnt_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        i2c_write_req = (op_q == OP_WRITE);
        i2c_read_req  = (op_q == OP_READ);
        if (ack_match || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        req_ack[idx_q] = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      op_q    <= OP_READ;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && gnt_valid) begin
        idx_q   <= gnt_idx;
        ptr_q   <= gnt_idx;
        op_q    <= (|(gnt_oh & req_write)) ? OP_WRITE : OP_READ;
        dev_q   <= req_dev_addr[{gnt_idx, 3'b000} +: 8];
        reg_q   <= req_reg_addr[{gnt_idx, 3'b000} +: 8];
        wdata_q <= req_wdata[{gnt_idx, 3'b000} +: 8];
      end
      if (ack_match) begin
        rdata_q <= (op_q == OP_READ) ? i2c_read_data : '0;
        err_q   <= i2c_error;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign req_rdata          = rdata_q;
  assign req_error          = err_q;
  assign i2c_slave_dev_addr = dev_q;
  assign i2c_slave_reg_addr = reg_q;
  assign i2c_write_data     = wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; the watchdog scenario runs when I2C_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_read, req_write, req_ack;
  logic [8*N-1:0] req_dev_addr, req_reg_addr, req_wdata;
  logic [7:0]     req_rdata;
  logic           req_error, busy;
  logic           i2c_read_req, i2c_read_req_ack, i2c_write_req, i2c_write_req_ack;
  logic [7:0]     i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data, i2c_read_data;
  logic           i2c_error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata), .req_error(req_error), .busy(busy),
    .i2c_read_req(i2c_read_req), .i2c_read_req_ack(i2c_read_req_ack),
    .i2c_write_req(i2c_write_req), .i2c_write_req_ack(i2c_write_req_ack),
    .i2c_slave_dev_addr(i2c_slave_dev_addr), .i2c_slave_reg_addr(i2c_slave_reg_addr),
    .i2c_write_data(i2c_write_data), .i2c_read_data(i2c_read_data), .i2c_error(i2c_error)
  );

  task automatic set_fields(input int i, input logic [7:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd);
    req_dev_addr[i*8 +: 8] = dev;
    req_reg_addr[i*8 +: 8] = rg;
    req_wdata[i*8 +: 8]    = wd;
  endtask

  // Master ack pulse, driven at a negedge; returns at the next negedge (arbiter in S_RESP).
  task automatic pulse_ack(input bit wr, input logic [7:0] rd, input bit err);
    if (wr) i2c_write_req_ack = 1'b1; else i2c_read_req_ack = 1'b1;
    i2c_read_data = rd;
    i2c_error     = err;
    @(negedge clk);
    i2c_write_req_ack = 1'b0;
    i2c_read_req_ack  = 1'b0;
    i2c_read_data     = 8'h00;
    i2c_error         = 1'b0;
  endtask

  task automatic wait_req(input bit wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr ? i2c_write_req : i2c_read_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b exp 0", busy); end
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ack: got %b exp 0000", req_ack); end
    vectors++; if (i2c_write_req !== 1'b0) begin miscompares++; $display("FAIL rst_wr_req: got %b exp 0", i2c_write_req); end
    vectors++; if (i2c_read_req !== 1'b0) begin miscompares++; $display("FAIL rst_rd_req: got %b exp 0", i2c_read_req); end
    vectors++; if (req_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata: got %h exp 00", req_rdata); end
    vectors++; if (req_error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %b exp 0", req_error); end
    vectors++; if (i2c_slave_dev_addr !== 8'h00) begin miscompares++; $display("FAIL rst_dev: got %h exp 00", i2c_slave_dev_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_write;
    set_fields(0, 8'h72, 8'h08, 8'h35);
    req_write[0] = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b exp 1", busy); end
    vectors++; if (i2c_write_req !== 1'b0) begin miscompares++; $display("FAIL wr_early: got %b exp 0", i2c_write_req); end
    @(negedge clk);
    vectors++; if (i2c_write_req !== 1'b1) begin miscompares++; $display("FAIL wr_latency: got %b exp 1", i2c_write_req); end
    vectors++; if (i2c_read_req !== 1'b0) begin miscompares++; $display("FAIL wr_rd_req: got %b exp 0", i2c_read_req); end
    vectors++; if (i2c_slave_dev_addr !== 8'h72) begin miscompares++; $display("FAIL wr_dev: got %h exp 72", i2c_slave_dev_addr); end
    vectors++; if (i2c_slave_reg_addr !== 8'h08) begin miscompares++; $display("FAIL wr_reg: got %h exp 08", i2c_slave_reg_addr); end
    vectors++; if (i2c_write_data !== 8'h35) begin miscompares++; $display("FAIL wr_data: got %h exp 35", i2c_write_data); end
    repeat (2) @(negedge clk);
    vectors++; if (i2c_write_req !== 1'b1) begin miscompares++; $display("FAIL wr_hold: got %b exp 1", i2c_write_req); end
    pulse_ack(1'b1, 8'h00, 1'b0);
    vectors++; if (i2c_write_req !== 1'b0) begin miscompares++; $display("FAIL wr_drop: got %b exp 0", i2c_write_req); end
    vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL wr_ack: got %b exp 0001", req_ack); end
    vectors++; if (req_error !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b exp 0", req_error); end
    req_write[0] = 1'b0;
    @(negedge clk);
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL wr_ack_pulse: got %b exp 0000", req_ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_read;
    bit ok;
    set_fields(2, 8'h50, 8'h1C, 8'h00);
    req_read[2] = 1'b1;
    wait_req(1'b0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_req_timeout: got 0 exp 1"); end
    vectors++; if (i2c_slave_dev_addr !== 8'h50) begin miscompares++; $display("FAIL rd_dev: got %h exp 50", i2c_slave_dev_addr); end
    vectors++; if (i2c_slave_reg_addr !== 8'h1C) begin miscompares++; $display("FAIL rd_reg: got %h exp 1C", i2c_slave_reg_addr); end
    i2c_write_req_ack = 1'b1;
    @(negedge clk);
    i2c_write_req_ack = 1'b0;
    vectors++; if (i2c_read_req !== 1'b1) begin miscompares++; $display("FAIL rd_wrong_ack_drop: got %b exp 1", i2c_read_req); end
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL rd_wrong_ack: got %b exp 0000", req_ack); end
    pulse_ack(1'b0, 8'hA5, 1'b0);
    vectors++; if (req_ack !== 4'b0100) begin miscompares++; $display("FAIL rd_ack: got %b exp 0100", req_ack); end
    vectors++; if (req_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_data: got %h exp A5", req_rdata); end
    vectors++; if (req_error !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b exp 0", req_error); end
    req_read[2] = 1'b0;
    @(negedge clk);
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL rd_ack_pulse: got %b exp 0000", req_ack); end
    vectors++; if (req_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_data_hold: got %h exp A5", req_rdata); end
  endtask

  task automatic test_nack;
    bit ok;
    set_fields(1, 8'h20, 8'h30, 8'h40);
    req_write[1] = 1'b1;
    wait_req(1'b1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL nack_req_timeout: got 0 exp 1"); end
    vectors++; if (i2c_slave_dev_addr !== 8'h20) begin miscompares++; $display("FAIL nack_dev: got %h exp 20", i2c_slave_dev_addr); end
    pulse_ack(1'b1, 8'hFF, 1'b1);
    vectors++; if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL nack_ack: got %b exp 0010", req_ack); end
    vectors++; if (req_error !== 1'b1) begin miscompares++; $display("FAIL nack_err: got %b exp 1", req_error); end
    vectors++; if (req_rdata !== 8'h00) begin miscompares++; $display("FAIL nack_rdata: got %h exp 00", req_rdata); end
    req_write[1] = 1'b0;
    @(negedge clk);
    set_fields(3, 8'h44, 8'h55, 8'h00);
    req_read[3] = 1'b1;
    wait_req(1'b0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL after_nack_timeout: got 0 exp 1"); end
    pulse_ack(1'b0, 8'h3C, 1'b0);
    vectors++; if (req_ack !== 4'b1000) begin miscompares++; $display("FAIL after_nack_ack: got %b exp 1000", req_ack); end
    vectors++; if (req_error !== 1'b0) begin miscompares++; $display("FAIL after_nack_err: got %b exp 0", req_error); end
    vectors++; if (req_rdata !== 8'h3C) begin miscompares++; $display("FAIL after_nack_rdata: got %h exp 3C", req_rdata); end
    req_read[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention;
    bit ok;
    int exp;
    for (int i = 0; i < N; i++) set_fields(i, 8'(16 + i), 8'(128 + i), 8'(192 + i));
    req_write = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp = k % N;
      wait_req(1'b1, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rr_req_timeout[%0d]: got 0 exp 1", k); end
      vectors++; if (i2c_slave_dev_addr !== 8'(16 + exp)) begin miscompares++; $display("FAIL rr_dev[%0d]: got %h exp %h", k, i2c_slave_dev_addr, 8'(16 + exp)); end
      pulse_ack(1'b1, 8'h00, 1'b0);
      vectors++; if (req_ack !== 4'(1 << exp)) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b exp %b", k, req_ack, 4'(1 << exp)); end
      req_write[exp] = 1'b0;
      @(negedge clk);
      if (k < 4) req_write[exp] = 1'b1;
      else req_write = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_wait;
    bit ok;
    set_fields(2, 8'h66, 8'h01, 8'h02);
    req_write[2] = 1'b1;
    wait_req(1'b1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rw_req_timeout: got 0 exp 1"); end
    vectors++; if (i2c_slave_dev_addr !== 8'h66) begin miscompares++; $display("FAIL rw_dev: got %h exp 66", i2c_slave_dev_addr); end
    rst_n = 1'b0;
    set_fields(0, 8'h77, 8'h03, 8'h04);
    req_write[0] = 1'b1;
    @(negedge clk);
    vectors++; if (i2c_write_req !== 1'b0) begin miscompares++; $display("FAIL rw_drop: got %b exp 0", i2c_write_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rw_busy: got %b exp 0", busy); end
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL rw_no_ack: got %b exp 0000", req_ack); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL rw_no_ack2: got %b exp 0000", req_ack); end
    wait_req(1'b1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rw_req2_timeout: got 0 exp 1"); end
    vectors++; if (i2c_slave_dev_addr !== 8'h77) begin miscompares++; $display("FAIL rw_first: got %h exp 77", i2c_slave_dev_addr); end
    pulse_ack(1'b1, 8'h00, 1'b0);
    vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL rw_ack0: got %b exp 0001", req_ack); end
    req_write[0] = 1'b0;
    @(negedge clk);
    wait_req(1'b1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rw_req3_timeout: got 0 exp 1"); end
    pulse_ack(1'b1, 8'h00, 1'b0);
    vectors++; if (req_ack !== 4'b0100) begin miscompares++; $display("FAIL rw_ack2: got %b exp 0100", req_ack); end
    req_write[2] = 1'b0;
    @(negedge clk);
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    set_fields(1, 8'h11, 8'h22, 8'h00);
    req_read[1] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        seen = 1'b1;
        break;
      end
      if (i2c_read_req) cnt++;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL to_no_ack: got 0 exp 1"); end
    vectors++; if (cnt != 100) begin miscompares++; $display("FAIL to_cycles: got %0d exp 100", cnt); end
    vectors++; if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL to_ack: got %b exp 0010", req_ack); end
    vectors++; if (req_error !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b exp 1", req_error); end
    vectors++; if (req_rdata !== 8'h00) begin miscompares++; $display("FAIL to_rdata: got %h exp 00", req_rdata); end
    vectors++; if (i2c_read_req !== 1'b0) begin miscompares++; $display("FAIL to_drop: got %b exp 0", i2c_read_req); end
    req_read[1] = 1'b0;
    @(negedge clk);
    i2c_read_req_ack = 1'b1;
    @(negedge clk);
    i2c_read_req_ack = 1'b0;
    @(negedge clk);
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL to_late_ack: got %b exp 0000", req_ack); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_late_busy: got %b exp 0", busy); end
  endtask
`endif

  initial begin
    rst_n             = 1'b0;
    req_read          = '0;
    req_write         = '0;
    req_dev_addr      = '0;
    req_reg_addr      = '0;
    req_wdata         = '0;
    i2c_read_req_ack  = 1'b0;
    i2c_write_req_ack = 1'b0;
    i2c_read_data     = 8'h00;
    i2c_error         = 1'b0;
    test_reset;
    test_single_write;
    test_read;
    test_nack;
    test_contention;
    test_reset_wait;
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
